io_port_ctrl: RTL
=================

// Module: io_port_ctrl
// PURPOSE
// - Memory-mapped I/O unit on the LEGLiteSingle data bus, beside data memory.
// - Decodes the top I/O window and serves the board I/O:
//   - two debounced switches with rise-edge capture
//   - a 7-segment hex display register
//   - a free-running 16-bit timer
// - io_hit steers the CPU read mux away from data memory.
// PARAMETERS
// - DEBOUNCE_CYCLES  4  consecutive stable synced samples before a switch value is accepted (>=1)
// - PRESCALE         1  clock cycles per timer increment (>=1)
// PORTS
// - clock       in   1   system clock; all state updates on the rising edge
// - reset       in   1   synchronous, active-high
// - draddr      in   16  CPU data address (ALU output)
// - dwdata      in   16  CPU write data
// - dwrite      in   1   write strobe, sampled at clock edge
// - dread       in   1   read strobe
// - io_sw0      in   1   raw switch 0 (asynchronous)
// - io_sw1      in   1   raw switch 1 (asynchronous)
// - io_rdata    out  16  read data, combinational
// - io_hit      out  1   draddr[15:3]==13'h1FFF (0xFFF8-0xFFFF), combinational
// - io_display  out  7   segments {g,f,e,d,c,b,a}, active-high
// BEHAVIOUR
// - Map: draddr[0] ignored; register select is draddr[2:1].
//   - 0xFFF8 SW:    R {14'b0,sw1_db,sw0_db}; writes ignored
//   - 0xFFFA EDGE:  R {14'b0,rise1,rise0}; W dwdata[1:0] are write-1-to-clear
//   - 0xFFFC DISP:  R {12'b0,disp}; W disp<=dwdata[3:0]
//   - 0xFFFE TIMER: R count; W count<=dwdata and prescaler<=0
// - io_rdata = selected reg when (io_hit & dread), else 16'h0000. Zero read latency.
// - Writes take effect at the clock edge when (io_hit & dwrite). Outside the window: no state change.
// - Reset values:
//   - sync flops, sw*_db, rise*, debounce counters: 0
//   - disp=0, so io_display=7'h3F
//   - count=0, prescaler=0
// - Switch path: 2-flop synchronizer, then debouncer.
//   - Counter increments while synced != db and clears when equal.
//   - db flips, and the counter clears, on the DEBOUNCE_CYCLES-th consecutive differing sample.
//   - Pin change to db change: DEBOUNCE_CYCLES+2 rising edges, counting the first sampling edge.
//   - A glitch shorter than DEBOUNCE_CYCLES synced samples never reaches db.
// - riseN sets on the same edge swN_db goes 0->1 and holds until cleared.
//   - Set and clear in the same cycle: set wins, bit reads 1.
//   - A switch held high through reset produces sw_db=1 and a rise event after reset. This is intended.
// - Timer: prescaler counts 0..PRESCALE-1; count increments on wrap; 0xFFFF wraps to 0x0000.
//   - A TIMER write in the same cycle as an increment wins, with no increment that cycle.
// - Hex decode, 0-F (hex, gfedcba):
//   3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71
// - Reset mid-debounce or mid-prescale discards partial counts. Nothing survives reset.
// STRUCTURE
// - Package io_port_pkg:
//   - IO_BASE, register offsets
//   - SEG_TABLE[16] constant
//   - counter-width function clog2
// - Sub-module switch_debounce: synchronizer, counter, db, rise pulse. Instantiated twice.
// - Top level holds the address decode, EDGE/DISP/TIMER registers, read mux and display decode.
// TESTING (DEBOUNCE_CYCLES=4, PRESCALE=1)
// - Reset, then read 0xFFFC and 0xFFFE:
//   - io_rdata=0x0000, io_display=7'h3F, io_hit=1
//   - io_rdata climbs 1 per cycle after the first read
// - io_sw0 0->1 held:
//   - SW reads 0x0001 exactly 6 edges later
//   - EDGE reads 0x0001
//   - write 0x0001 to 0xFFFA, then EDGE reads 0x0000
// - io_sw1 high for 3 cycles then low: SW and EDGE stay 0x0000 throughout.
// - Write 0x000B to 0xFFFC: io_display=7'h7C next cycle; read returns 0x000B.
//   Write 0x1234 to 0x0010: io_hit=0, no I/O state change, io_rdata=0.
// - Write 0xFFFF to 0xFFFE:
//   - reads 0xFFFF, then 0x0000 the next cycle (wrap)
//   - write EDGE clear on the cycle rise0 sets: bit remains 1

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared definitions for the LEGLiteSingle memory-mapped I/O unit:
// window base, register select encoding, segment table and width helper.
package io_port_pkg;

    localparam logic [15:0] IO_BASE = 16'hFFF8;

    // Register select is draddr[2:1]; byte offsets are 0, 2, 4, 6 from IO_BASE.
    typedef enum logic [1:0] {
        REG_SW    = 2'd0,
        REG_EDGE  = 2'd1,
        REG_DISP  = 2'd2,
        REG_TIMER = 2'd3
    } io_reg_e;

    // Active-high segments {g,f,e,d,c,b,a} for hex digits 0-F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/io_port_ctrl_switch_debounce.sv
// Two-flop synchronizer plus counting debouncer for one board switch,
// with a one-cycle rise indication aligned to the debounced 0->1 edge.
module switch_debounce
    import io_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_db,
    output logic rise
);

    localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_out;
    logic [CW-1:0] stable_cnt;
    logic          accept;

    // The DEBOUNCE_CYCLES-th consecutive differing sample commits the new value.
    assign accept = (sync_out != sw_db) && (stable_cnt == CNT_LAST);
    assign rise   = accept && sync_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_out   <= 1'b0;
            sw_db      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_meta <= sw_raw;
            sync_out  <= sync_meta;
            if (sync_out == sw_db) begin
                stable_cnt <= '0;
            end else if (accept) begin
                sw_db      <= sync_out;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// I/O window at 0xFFF8-0xFFFF: debounced switches, edge capture, hex display
// register and a free-running prescaled 16-bit timer, all with zero-latency reads.
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRESCALE        = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] draddr,
    input  logic [15:0] dwdata,
    input  logic        dwrite,
    input  logic        dread,
    input  logic        io_sw0,
    input  logic        io_sw1,
    output logic [15:0] io_rdata,
    output logic        io_hit,
    output logic [6:0]  io_display
);

    localparam int PW = clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    io_reg_e       reg_sel;
    logic          wr_en;
    logic [1:0]    sw_db;
    logic [1:0]    rise_set;
    logic [1:0]    rise_flag;
    logic [1:0]    edge_clear;
    logic [3:0]    disp;
    logic [15:0]   count;
    logic [PW-1:0] prescaler;
    logic          tick;

    // Byte lane bit is not part of the register decode.
    logic unused_addr_bit;
    assign unused_addr_bit = draddr[0];

    assign io_hit  = (draddr[15:3] == IO_BASE[15:3]);
    assign reg_sel = io_reg_e'(draddr[2:1]);
    assign wr_en   = io_hit && dwrite;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw0 (
        .clock  (clock),
        .reset  (reset),
        .sw_raw (io_sw0),
        .sw_db  (sw_db[0]),
        .rise   (rise_set[0])
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
        .clock  (clock),
        .reset  (reset),
        .sw_raw (io_sw1),
        .sw_db  (sw_db[1]),
        .rise   (rise_set[1])
    );

    // A new rise beats a simultaneous write-1-to-clear.
    assign edge_clear = (wr_en && (reg_sel == REG_EDGE)) ? dwdata[1:0] : 2'b00;

    always_ff @(posedge clock) begin
        if (reset) begin
            rise_flag <= 2'b00;
            disp      <= 4'h0;
        end else begin
            rise_flag <= rise_set | (rise_flag & ~edge_clear);
            if (wr_en && (reg_sel == REG_DISP)) begin
                disp <= dwdata[3:0];
            end
        end
    end

    assign tick = (prescaler == PRE_LAST);

    // A TIMER write replaces the count and restarts the prescaler, suppressing that cycle's increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= 16'h0000;
            prescaler <= '0;
        end else if (wr_en && (reg_sel == REG_TIMER)) begin
            count     <= dwdata;
            prescaler <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) begin
                count <= count + 16'h0001;
            end
        end
    end

    always_comb begin
        io_rdata = 16'h0000;
        if (io_hit && dread) begin
            case (reg_sel)
                REG_SW:    io_rdata = {14'b0, sw_db};
                REG_EDGE:  io_rdata = {14'b0, rise_flag};
                REG_DISP:  io_rdata = {12'b0, disp};
                REG_TIMER: io_rdata = count;
                default:   io_rdata = 16'h0000;
            endcase
        end
    end

    assign io_display = SEG_TABLE[disp];

endmodule
